led_fade_pwm: RTL and testbench
===============================

// Module: led_fade_pwm
// PURPOSE
//  Downstream stage of the LED flow generator.
//  - Takes the raw 4-bit on/off LED pattern and drives the board LEDs through per-channel PWM.
//  - Each LED fades linearly up or down toward its target instead of switching hard.
//  - Sits between the flow pattern generator and the LED pins.
// PARAMETERS
//  N_LED     4       number of LED channels
//  PWM_BITS  8       duty/PWM counter width; MAX = 2**PWM_BITS-1; PWM period = 2**PWM_BITS clocks
//  STEP_DIV  2000    clocks per brightness step; full fade = MAX*STEP_DIV clocks
// PORTS
//  sys_clk   in   1      system clock (50 MHz board clock)
//  sys_rst   in   1      reset, synchronous, active-high
//  enable    in   1      1 = normal operation; 0 = all LEDs dark immediately
//  led_in    in   N_LED  target pattern from flow generator (1 = LED should be on)
//  led_out   out  N_LED  PWM-modulated LED drive, registered
//  fading    out  1      registered; 1 while any channel duty != its target level
// BEHAVIOUR
//  - Reset (sys_rst=1 at a clock edge): all of the following are 0 from the next cycle.
//    - Registers: pwm_cnt, step_cnt, every duty[i], tgt_q.
//    - Outputs: led_out=0, fading=0.
//    - Reset mid-fade aborts the fade with no residual state.
//  - Input register:
//    - tgt_q <= led_in every cycle (1-cycle latency).
//    - Target level for channel i is MAX if tgt_q[i], else 0.
//  - pwm_cnt: free-running 0..MAX, wraps MAX->0.
//  - step_cnt: 0..STEP_DIV-1, wraps.
//    - step_tick = (step_cnt == STEP_DIV-1), one cycle wide.
//  - Per-channel FSM, updated only on step_tick:
//    - OFF (duty=0): target=MAX -> RISE.
//    - RISE: duty+1 per tick; duty reaches MAX -> ON; target=0 -> FALL (direction reverses from the current duty, no jump).
//    - ON (duty=MAX): target=0 -> FALL.
//    - FALL: duty-1 per tick; duty reaches 0 -> OFF; target=MAX -> RISE.
//    - duty saturates at 0 and MAX; it never wraps.
//  - Target change between ticks: takes effect at the next step_tick only.
//  - PWM output:
//    - led_out[i] <= (duty[i]==MAX) ? 1 : (pwm_cnt < duty[i]).
//    - duty=0 -> constant 0; duty=MAX -> constant 1 (no glitch).
//  - fading <= OR over i of (duty[i] != target level of i).
//  - enable=0, effective at the next edge:
//    - duty[i]=0, FSM=OFF, step_cnt=0, led_out=0, fading=0.
//    - pwm_cnt keeps running.
//    - tgt_q still tracks led_in.
//  - enable rising: channels with target=1 start RISE from 0.
//  - Width rules:
//    - step_cnt width = $clog2(STEP_DIV).
//    - duty and pwm_cnt are PWM_BITS wide, unsigned.
//    - Compare is unsigned.
// STRUCTURE
//  - Package led_pkg: PWM_BITS default, fade state enum {OFF,RISE,ON,FALL}, DUTY_MAX constant.
//  - Top owns tgt_q, pwm_cnt, step_cnt/step_tick and the fading OR-reduce.
//  - Sub-module led_fade_channel (generate loop, N_LED instances).
//    - Inputs: sys_clk, sys_rst, enable, step_tick, target, pwm_cnt.
//    - Owns the channel FSM and duty register.
//    - Outputs: led_out bit, at_target.
// TESTING  (bench parameters: PWM_BITS=4 (MAX=15), STEP_DIV=4; sys_clk period 20 ns)
//  1 Hold sys_rst=1 for 10 cycles with led_in=4'b1111
//    -> led_out=0, fading=0 throughout and 1 cycle after release.
//  2 led_in=4'b0001, enable=1
//    -> fading=1 within 2 cycles.
//    -> duty[0] reaches 15 after 15 step_ticks (~60 clks), then fading=0.
//    -> led_out[0] constant 1; led_out[3:1]=0.
//  3 In the same ramp, set led_in=4'b0000 when duty[0]=7
//    -> next tick duty[0]=6, reaches 0 after 7 ticks.
//    -> led_out[0] then constant 0; fading falls.
//  4 Freeze duty[0] at 8 by setting STEP_DIV large after the ramp
//    -> led_out[0] high exactly 8 of every 16 clocks, aligned to pwm_cnt 0..7.
//  5 Deassert enable mid-rise (duty=5)
//    -> next cycle led_out=0, fading=0, duty=0.
//    -> reassert with led_in=1: ramp restarts from 0.
//  6 Pulse sys_rst for 1 cycle mid-fall, led_in=4'b1010
//    -> led_out=0 next cycle; channels 1 and 3 ramp from 0 after release.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and fade-state encoding for the LED fader.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int unsigned PWM_BITS_DEF = 8;

    function automatic int unsigned duty_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned DUTY_MAX = duty_max(PWM_BITS_DEF);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fade_state_e;

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_channel
// Description : One LED channel: linear fade FSM, duty register, PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic                step_tick,
    input  logic                target,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] C_MAX = PWM_BITS'(duty_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] C_ONE = PWM_BITS'(1);

    fade_state_e         state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        // Full duty bypasses the compare so the LED is solidly on, no gap at wrap.
        led_d   = enable & ((duty_q == C_MAX) | (pwm_cnt < duty_q));
        if (!enable) begin
            state_d = OFF;
            duty_d  = '0;
        end else if (step_tick) begin
            unique case (state_q)
                OFF: begin
                    if (target) begin
                        duty_d  = duty_q + C_ONE;
                        state_d = (duty_d == C_MAX) ? ON : RISE;
                    end
                end
                RISE, FALL: begin
                    if (target && (duty_q != C_MAX)) begin
                        duty_d  = duty_q + C_ONE;
                        state_d = (duty_d == C_MAX) ? ON : RISE;
                    end else if (!target && (duty_q != '0)) begin
                        duty_d  = duty_q - C_ONE;
                        state_d = (duty_d == '0) ? OFF : FALL;
                    end
                end
                ON: begin
                    if (!target) begin
                        duty_d  = duty_q - C_ONE;
                        state_d = (duty_d == '0) ? OFF : FALL;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= OFF;
            duty_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign led_out   = led_q;
    assign at_target = (duty_q == (target ? C_MAX : '0));

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_pwm
// Description : Fades each LED of an on/off pattern up/down through PWM.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned PWM_BITS = PWM_BITS_DEF,
    parameter int unsigned STEP_DIV = 2000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic [N_LED-1:0] led_in,
    output logic [N_LED-1:0] led_out,
    output logic             fading
);

    localparam int unsigned       SW          = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0]     C_STEP_LAST = SW'(STEP_DIV - 1);

    logic [N_LED-1:0]    tgt_q, tgt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic                fading_q, fading_d;
    logic                step_tick;
    logic [N_LED-1:0]    at_target;

    assign step_tick = (step_cnt_q == C_STEP_LAST);

    always_comb begin
        tgt_d      = led_in;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        step_cnt_d = step_cnt_q + SW'(1);
        // Disabling parks the divider so a re-enable starts a full step interval.
        if (!enable || step_tick) begin
            step_cnt_d = '0;
        end
        fading_d   = enable & ~(&at_target);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tgt_q      <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            fading_q   <= 1'b0;
        end else begin
            tgt_q      <= tgt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            fading_q   <= fading_d;
        end
    end

    generate
        for (genvar i = 0; i < N_LED; i++) begin : g_ch
            led_fade_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_ch (
                .sys_clk   (sys_clk),
                .sys_rst   (sys_rst),
                .enable    (enable),
                .step_tick (step_tick),
                .target    (tgt_q[i]),
                .pwm_cnt   (pwm_cnt_q),
                .led_out   (led_out[i]),
                .at_target (at_target[i])
            );
        end
    endgenerate

    assign fading = fading_q;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_fade_pwm
// Description : Scoreboard bench for led_fade_pwm (MAX=15, STEP_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fade_pwm;

    localparam int MAXV = 15;
    localparam int SD   = 4;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b1;
    logic       enable   = 1'b0;
    logic       enable_s = 1'b0;
    logic [3:0] led_in   = 4'b0;
    logic [3:0] led_in_s = 4'b0;
    logic [3:0] led_out, led_out_s;
    logic       fading, fading_s;

    always #10 sys_clk = ~sys_clk;

    led_fade_pwm #(.N_LED(4), .PWM_BITS(4), .STEP_DIV(SD)) dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .enable (enable),
        .led_in  (led_in),  .led_out (led_out), .fading (fading)
    );

    // Slow-stepping instance: duty holds still for several PWM periods.
    led_fade_pwm #(.N_LED(4), .PWM_BITS(4), .STEP_DIV(64)) dut_slow (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .enable (enable_s),
        .led_in  (led_in_s), .led_out (led_out_s), .fading (fading_s)
    );

    int         m_duty [4];
    logic [3:0] m_tgt;
    int         m_pwm, m_pwm_prev, m_step;
    logic [4:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    // Behavioural reference: advances one clock, queues the expected outputs.
    task automatic clk_step();
        logic [3:0] nled;
        logic       nfad;
        bit         tick;
        m_pwm_prev = m_pwm;
        nled = 4'b0;
        nfad = 1'b0;
        if (sys_rst) begin
            for (int i = 0; i < 4; i++) m_duty[i] = 0;
            m_tgt = 4'b0; m_pwm = 0; m_step = 0;
        end else begin
            tick = enable && (m_step == SD - 1);
            for (int i = 0; i < 4; i++) begin
                nled[i] = enable && (m_duty[i] == MAXV || m_pwm < m_duty[i]);
                if (enable && m_duty[i] != (m_tgt[i] ? MAXV : 0)) nfad = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!enable) m_duty[i] = 0;
                else if (tick && m_tgt[i] && m_duty[i] < MAXV) m_duty[i]++;
                else if (tick && !m_tgt[i] && m_duty[i] > 0) m_duty[i]--;
            end
            m_step = (!enable || tick) ? 0 : m_step + 1;
            m_pwm  = (m_pwm + 1) % 16;
            m_tgt  = led_in;
        end
        exp_q.push_back({nled, nfad});
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        sys_rst = 1'b1; enable = 1'b1; led_in = 4'b1111;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) sys_rst = 1'b0;
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL reset_model c=%0d: got %b expected %b", c, {led_out, fading}, e);
            end
            checks++;
            if ({led_out, fading} !== 5'b0) begin
                errors++; $display("FAIL reset_zero c=%0d: got %b expected 00000", c, {led_out, fading});
            end
        end
    endtask

    task automatic test_rise();
        logic [4:0] e;
        int rise_at = -1, fall_at = -1;
        led_in = 4'b0001; enable = 1'b1;
        for (int c = 1; c <= 100 && fall_at < 0; c++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL rise_model c=%0d: got %b expected %b", c, {led_out, fading}, e);
            end
            if (fading === 1'b1 && rise_at < 0) rise_at = c;
            if (fading === 1'b0 && rise_at >= 0) fall_at = c;
        end
        checks++;
        if (rise_at < 1 || rise_at > 2) begin
            errors++; $display("FAIL rise_fading_start: got cycle %0d expected 1..2", rise_at);
        end
        checks++;
        if (fall_at < 56 || fall_at > 64) begin
            errors++; $display("FAIL rise_fading_end: got cycle %0d expected 56..64", fall_at);
        end
        for (int c = 0; c < 16; c++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== 5'b00010 || e !== 5'b00010) begin
                errors++; $display("FAIL rise_full c=%0d: got %b model %b expected 00010", c, {led_out, fading}, e);
            end
        end
    endtask

    task automatic test_reverse();
        logic [4:0] e;
        int n = 0, fall_at = -1;
        enable = 1'b0;
        clk_step(); void'(exp_q.pop_front());
        enable = 1'b1; led_in = 4'b0001;
        while (m_duty[0] != 7 && n < 60) begin
            clk_step(); n++;
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL rev_up_model n=%0d: got %b expected %b", n, {led_out, fading}, e);
            end
        end
        checks++;
        if (m_duty[0] != 7) begin
            errors++; $display("FAIL rev_reach7: got duty %0d expected 7", m_duty[0]);
        end
        led_in = 4'b0000;
        for (int c = 1; c <= 60 && fall_at < 0; c++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL rev_down_model c=%0d: got %b expected %b", c, {led_out, fading}, e);
            end
            if (fading === 1'b0) fall_at = c;
        end
        checks++;
        if (fall_at < 25 || fall_at > 33) begin
            errors++; $display("FAIL rev_fall_time: got cycle %0d expected 25..33", fall_at);
        end
        for (int c = 0; c < 16; c++) begin
            clk_step(); void'(exp_q.pop_front());
            checks++;
            if ({led_out, fading} !== 5'b0) begin
                errors++; $display("FAIL rev_dark c=%0d: got %b expected 00000", c, {led_out, fading});
            end
        end
    endtask

    task automatic test_pwm_duty();
        logic [4:0] e;
        logic [3:0] want;
        int highs = 0;
        led_in_s = 4'b0001; enable_s = 1'b1;
        for (int k = 0; k <= 567; k++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL pwm_main_model k=%0d: got %b expected %b", k, {led_out, fading}, e);
            end
            if (k >= 520) begin
                want = {3'b000, (m_pwm_prev < 8) ? 1'b1 : 1'b0};
                checks++;
                if (led_out_s !== want) begin
                    errors++; $display("FAIL pwm_half k=%0d pwm=%0d: got %b expected %b", k, m_pwm_prev, led_out_s, want);
                end
                if (k < 536 && led_out_s[0] === 1'b1) highs++;
            end
            if (k == 540) begin
                checks++;
                if (fading_s !== 1'b1) begin
                    errors++; $display("FAIL pwm_fading: got %b expected 1", fading_s);
                end
            end
        end
        checks++;
        if (highs != 8) begin
            errors++; $display("FAIL pwm_high_count: got %0d expected 8", highs);
        end
        enable_s = 1'b0; led_in_s = 4'b0;
    endtask

    task automatic test_enable();
        logic [4:0] e;
        int n = 0;
        led_in = 4'b0001; enable = 1'b1;
        while (m_duty[0] != 5 && n < 60) begin
            clk_step(); n++;
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL en_up_model n=%0d: got %b expected %b", n, {led_out, fading}, e);
            end
        end
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            clk_step(); void'(exp_q.pop_front());
            checks++;
            if ({led_out, fading} !== 5'b0) begin
                errors++; $display("FAIL en_off c=%0d: got %b expected 00000", c, {led_out, fading});
            end
        end
        enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL en_restart_model c=%0d: got %b expected %b", c, {led_out, fading}, e);
            end
            if (c < 4) begin
                checks++;
                if (led_out[0] !== 1'b0) begin
                    errors++; $display("FAIL en_from_zero c=%0d: got %b expected 0", c, led_out[0]);
                end
            end
        end
    endtask

    task automatic test_rst_mid_fall();
        logic [4:0] e;
        int n = 0;
        led_in = 4'b1010;
        while (m_duty[1] != 10 && n < 80) begin
            clk_step(); n++; void'(exp_q.pop_front());
        end
        led_in = 4'b0000;
        n = 0;
        while (m_duty[1] != 6 && n < 80) begin
            clk_step(); n++;
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL rst_fall_model n=%0d: got %b expected %b", n, {led_out, fading}, e);
            end
        end
        led_in = 4'b1010; sys_rst = 1'b1;
        clk_step(); void'(exp_q.pop_front());
        sys_rst = 1'b0;
        checks++;
        if ({led_out, fading} !== 5'b0) begin
            errors++; $display("FAIL rst_pulse: got %b expected 00000", {led_out, fading});
        end
        for (int c = 0; c < 80; c++) begin
            clk_step();
            e = exp_q.pop_front();
            checks++;
            if ({led_out, fading} !== e) begin
                errors++; $display("FAIL rst_ramp_model c=%0d: got %b expected %b", c, {led_out, fading}, e);
            end
        end
        checks++;
        if ({led_out, fading} !== 5'b10100) begin
            errors++; $display("FAIL rst_ramp_final: got %b expected 10100", {led_out, fading});
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_duty[i] = 0;
        m_tgt = 4'b0; m_pwm = 0; m_pwm_prev = 0; m_step = 0;
        test_reset();
        test_rise();
        test_reverse();
        test_pwm_duty();
        test_enable();
        test_rst_mid_fall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
